// File: rtl/jk_updown_counter.sv
// Modulo-MODULUS up/down counter whose state bits are J-K storage stages.
// Supports synchronous reset, parallel load with clamping, terminal count and a wrap pulse.
module jk_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_bar_o,
    output logic             tc_o,
    output logic             wrap_o
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] jBits;
    logic [WIDTH-1:0] kBits;
    logic             wrap_q;
    logic             wrap_d;
    logic             atMax;
    logic             atZero;

    assign atMax  = (count_q == MAX_VAL);
    assign atZero = (count_q == '0);

    // Target value the counter should reach; wrap happens only on a counting step.
    always_comb begin
        target = count_q;
        wrap_d = 1'b0;
        if (load_i) begin
            target = ({1'b0, d_i} < MOD_EXT) ? d_i : MAX_VAL;
        end else if (en_i) begin
            if (up_i) begin
                target = atMax ? '0 : count_q + 1'b1;
                wrap_d = atMax;
            end else begin
                target = atZero ? MAX_VAL : count_q - 1'b1;
                wrap_d = atZero;
            end
        end
    end

    // Derive J/K excitations from the desired transition, then apply J-K behaviour per bit.
    always_comb begin
        jBits   = ~count_q & target;
        kBits   = count_q & ~target;
        count_d = count_q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({jBits[i], kBits[i]})
                2'b10:   count_d[i] = 1'b1;
                2'b01:   count_d[i] = 1'b0;
                2'b11:   count_d[i] = ~count_q[i];
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q_o     = count_q;
    assign q_bar_o = ~count_q;
    assign wrap_o  = wrap_q;
    assign tc_o    = en_i & ~load_i & ((up_i & atMax) | (~up_i & atZero));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench for jk_updown_counter: directed scenarios plus random traffic
// compared against an arithmetic reference model of the counting rules.
module tb_jk_updown_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic [W-1:0] qBar;
    logic         tc;
    logic         wrap;

    int  compared = 0;
    int  mismatched = 0;
    int  modelQ = 0;
    int  modelWrap = 0;
    bit  modelKnown = 1'b0;

    jk_updown_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (en),
        .up_i    (up),
        .load_i  (load),
        .d_i     (d),
        .q_o     (q),
        .q_bar_o (qBar),
        .tc_o    (tc),
        .wrap_o  (wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, check TC before the edge, then advance the model and check state.
    task automatic applyStimulus(input logic r, input logic l, input logic e,
                                 input logic u, input logic [W-1:0] dv);
        int expTc;
        reset = r; load = l; en = e; up = u; d = dv;
        #1;
        if (modelKnown) begin
            expTc = (e && !l && ((u && modelQ == MOD - 1) || (!u && modelQ == 0))) ? 1 : 0;
            checkOutput("tc", tc, expTc);
        end
        @(posedge clk);
        if (r) begin
            modelQ = 0; modelWrap = 0; modelKnown = 1'b1;
        end else if (l) begin
            modelQ = (int'(dv) < MOD) ? int'(dv) : MOD - 1;
            modelWrap = 0;
        end else if (e) begin
            if (u) begin
                modelWrap = (modelQ == MOD - 1) ? 1 : 0;
                modelQ = (modelQ + 1) % MOD;
            end else begin
                modelWrap = (modelQ == 0) ? 1 : 0;
                modelQ = (modelQ + MOD - 1) % MOD;
            end
        end else begin
            modelWrap = 0;
        end
        #1;
        if (modelKnown) begin
            checkOutput("q", q, modelQ);
            checkOutput("qbar", qBar, (~modelQ) & ((1 << W) - 1));
            checkOutput("wrap", wrap, modelWrap);
        end
    endtask

    initial begin
        int exp31[12];
        int exp32[6];
        int wrapCount;
        exp31 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        exp32 = '{3, 2, 1, 0, 9, 8};

        @(posedge clk); #1;

        // Reset dominates a simultaneous load
        applyStimulus(1, 1, 0, 1, 4'd7);
        applyStimulus(1, 1, 0, 1, 4'd7);
        checkOutput("rst_q", q, 0);
        checkOutput("rst_qbar", qBar, 15);
        checkOutput("rst_wrap", wrap, 0);

        // Count up through the wrap
        wrapCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 0, 1, 1, 4'd0);
            checkOutput("up_seq", q, exp31[i]);
            wrapCount += wrap;
        end
        checkOutput("up_wraps", wrapCount, 1);

        // Load then count down through the wrap
        applyStimulus(0, 1, 0, 0, 4'd3);
        checkOutput("dn_seq", q, exp32[0]);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(0, 0, 1, 0, 4'd0);
            checkOutput("dn_seq", q, exp32[i]);
        end

        // Clamped load, and load beating enable
        applyStimulus(0, 1, 0, 1, 4'd12);
        checkOutput("clamp", q, 9);
        applyStimulus(0, 1, 1, 1, 4'd2);
        checkOutput("load_wins", q, 2);

        // Reset mid-count then resume
        applyStimulus(0, 1, 0, 1, 4'd5);
        applyStimulus(1, 0, 1, 1, 4'd0);
        checkOutput("midrst", q, 0);
        applyStimulus(0, 0, 1, 1, 4'd0);
        checkOutput("resume", q, 1);

        // Hold while toggling direction
        applyStimulus(0, 1, 0, 0, 4'd6);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, i[0], 4'd0);
            checkOutput("hold", q, 6);
        end

        // Reset pulse between edges must not disturb state
        reset = 1'b1; #2; reset = 1'b0; #1;
        checkOutput("glitch_rst", q, 6);
        applyStimulus(0, 0, 0, 1, 4'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                          W'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (range 2..8).
REQ-002 Parameter MODULUS, default 10, count sequence length (range 2..2^WIDTH).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset; sampled only on rising Clk.
REQ-005 En  input  1  count enable; counter advances one step per cycle while high.
REQ-006 Up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 Load  input  1  synchronous parallel load strobe.
REQ-008 D  input  WIDTH  parallel load value.
REQ-009 Q  output  WIDTH  registered count value.
REQ-010 Q_bar  output  WIDTH  bitwise complement of Q, always exactly ~Q.
REQ-011 TC  output  1  terminal count, combinational: En high and next step wraps.
REQ-012 Wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.

Function
REQ-013 Each bit of Q SHALL be held in a J-K storage stage; per-bit J = ~Q[i] & next[i], K = Q[i] & ~next[i], so J=K=0 holds, J=K=1 never occurs except via toggle-free encoding.
REQ-014 Priority per rising edge SHALL be Reset > Load > En > hold.
REQ-015 Load=1: Q <= D if D < MODULUS, else Q <= MODULUS-1 (clamp); Up and En ignored; Wrap <= 0.
REQ-016 En=1, Up=1, Q < MODULUS-1: Q <= Q+1; Wrap <= 0.
REQ-017 En=1, Up=1, Q = MODULUS-1: Q <= 0; Wrap <= 1.
REQ-018 En=1, Up=0, Q > 0: Q <= Q-1; Wrap <= 0.
REQ-019 En=1, Up=0, Q = 0: Q <= MODULUS-1; Wrap <= 1.
REQ-020 En=0, Load=0: Q holds; Wrap <= 0.
REQ-021 TC = En & ~Load & ((Up & Q==MODULUS-1) | (~Up & Q==0)); used for cascading stages.
REQ-022 Direction change takes effect on the same edge Up is sampled; no extra latency.
REQ-023 Latency: Q reflects any Load/count operation one cycle after the sampling edge.
REQ-024 Q SHALL never hold a value >= MODULUS under any input sequence.
REQ-025 Arithmetic SHALL be modulo MODULUS; no intermediate carries beyond WIDTH bits reach Q.

Reset
REQ-026 Reset=1 at rising edge: Q <= 0, Q_bar <= all ones, Wrap <= 0, regardless of Load/En.
REQ-027 Reset asserted mid-count SHALL abort the sequence; counting resumes from 0 on first edge after Reset deasserts.
REQ-028 Before the first rising edge with Reset=1, output values are undefined; bench SHALL assert Reset for at least one edge.
REQ-029 Reset SHALL have no asynchronous effect; a Reset pulse not spanning a rising edge SHALL change nothing.

Verification
REQ-030 Reset=1 for 2 cycles with Load=1, D=7 -> Q=0, Q_bar=4'b1111, Wrap=0.
REQ-031 Defaults, En=1, Up=1 from 0 for 12 cycles -> Q 1..9,0,1,2; TC high while Q=9; Wrap pulses once, cycle after 9->0.
REQ-032 Load=1, D=3, then En=1, Up=0 for 5 cycles -> Q 3,2,1,0,9,8; Wrap pulse after 0->9; TC high at Q=0.
REQ-033 Load=1, D=12 (>= MODULUS) -> Q=9; Load=1 with En=1 same edge -> load wins.
REQ-034 Counting up at Q=5, Reset=1 one edge, then En=1 -> Q 0, then 1; Wrap=0 throughout.
REQ-035 En=0, toggle Up each cycle for 4 cycles at Q=6 -> Q stays 6, TC=0, Wrap=0; Q_bar=~Q every cycle.
